// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer sharing one W-bit enabled register between N requesters.
// Latency: req sampled on edge k -> gnt/q updated after edge k (1 cycle), then HOLD lockout cycles.
// Backpressure: level requests simply wait (no queueing); busy=1 while locked out, gnt masks own req.
module reg_write_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [N-1:0]                          req,
    input  logic [N*W-1:0]                        din,
    output logic [N-1:0]                          gnt,
    output logic [W-1:0]                          q,
    output logic                                  q_valid,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  owner,
    output logic                                  busy
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [OW-1:0] ptr;
    logic [N-1:0]  ereq;
    logic          win_found;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] win_next;

    // A requester whose grant is showing this cycle cannot win again on the same edge.
    assign ereq = req & ~gnt;
    assign busy = (state == ST_HOLD);

    // Pick the first active effective request at or above ptr, wrapping from N-1 to 0.
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            idx  = (int'(ptr) + k) % N;
            cand = OW'(idx);
            if (!win_found && ereq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Round-robin pointer advances to the requester just after the winner.
    always_comb begin
        win_next = '0;
        if (win_idx != OW'(N - 1)) begin
            win_next = win_idx + 1'b1;
        end
    end

    // Grant sequencer and the shared register: q only loads on a grant edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            owner   <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        q       <= din[win_idx*W +: W];
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        owner   <= win_idx;
                        q_valid <= 1'b1;
                        ptr     <= win_next;
                        if (HOLD > 0) begin
                            state <= ST_HOLD;
                            cnt   <= CW'(HOLD);
                        end
                    end
                end
                ST_HOLD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: three instances (HOLD = 2, 0, 3) share one stimulus stream.
// Each instance is compared every cycle against a countdown-based reference model.
// Directed steps follow the plan, then a randomized phase with occasional async resets.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ND = 3;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N*W-1:0] din;

    logic [N-1:0]  gnt_o   [ND];
    logic [W-1:0]  q_o     [ND];
    logic          qv_o    [ND];
    logic [1:0]    owner_o [ND];
    logic          busy_o  [ND];

    int total;
    int bad;

    // Reference model: lockout expressed as "cycles left", no FSM.
    int hold_of [ND];
    int m_left  [ND];
    int m_ptr   [ND];
    int m_q     [ND];
    int m_qv    [ND];
    int m_owner [ND];
    int m_gnt   [ND];

    reg_write_arbiter #(.N(N), .W(W), .HOLD(2)) u_h2 (
        .clk(clk), .reset_n(reset_n), .req(req), .din(din),
        .gnt(gnt_o[0]), .q(q_o[0]), .q_valid(qv_o[0]), .owner(owner_o[0]), .busy(busy_o[0])
    );
    reg_write_arbiter #(.N(N), .W(W), .HOLD(0)) u_h0 (
        .clk(clk), .reset_n(reset_n), .req(req), .din(din),
        .gnt(gnt_o[1]), .q(q_o[1]), .q_valid(qv_o[1]), .owner(owner_o[1]), .busy(busy_o[1])
    );
    reg_write_arbiter #(.N(N), .W(W), .HOLD(3)) u_h3 (
        .clk(clk), .reset_n(reset_n), .req(req), .din(din),
        .gnt(gnt_o[2]), .q(q_o[2]), .q_valid(qv_o[2]), .owner(owner_o[2]), .busy(busy_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_left[d] = 0; m_ptr[d] = 0; m_q[d] = 0; m_qv[d] = 0;
            m_owner[d] = 0; m_gnt[d] = 0;
        end
    endtask

    // One rising edge of the reference: pending lockout burns a cycle, otherwise serve
    // the next requester in circular order starting at ptr.
    task automatic model_edge();
        int e;
        int w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < ND; d++) begin
            e = int'(req) & ~m_gnt[d] & 15;
            if (m_left[d] > 0) begin
                m_left[d]--;
                m_gnt[d] = 0;
            end else if (e != 0) begin
                w = -1;
                for (int k = 0; k < N && w < 0; k++) begin
                    if (e[(m_ptr[d] + k) % N]) w = (m_ptr[d] + k) % N;
                end
                m_q[d]     = int'((din >> (W * w)) & 32'hFF);
                m_qv[d]    = 1;
                m_owner[d] = w;
                m_gnt[d]   = 1 << w;
                m_ptr[d]   = (w + 1) % N;
                m_left[d]  = hold_of[d];
            end else begin
                m_gnt[d] = 0;
            end
        end
    endtask

    task automatic compare_all(input string where);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s.d%0d.gnt", where, d),   32'(gnt_o[d]),   32'(m_gnt[d]));
            chk($sformatf("%s.d%0d.q", where, d),     32'(q_o[d]),     32'(m_q[d]));
            chk($sformatf("%s.d%0d.qv", where, d),    32'(qv_o[d]),    32'(m_qv[d]));
            chk($sformatf("%s.d%0d.owner", where, d), 32'(owner_o[d]), 32'(m_owner[d]));
            chk($sformatf("%s.d%0d.busy", where, d),  32'(busy_o[d]),  32'(m_left[d] > 0));
        end
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(where);
    endtask

    // Synchronous-looking reset pulse through one edge, released just after an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        step("rst");
        reset_n = 1'b1;
    endtask

    initial begin
        int gl [$];
        int gs [$];
        total = 0;
        bad   = 0;
        hold_of[0] = 2; hold_of[1] = 0; hold_of[2] = 3;
        model_reset();

        // Reset with every requester active and all-ones data.
        reset_n = 1'b0;
        req     = 4'b1111;
        din     = 32'hFFFF_FFFF;
        #2;
        for (int i = 0; i < 3; i++) begin
            step("reset");
            chk("reset.q", 32'(q_o[0]), 32'h0);
            chk("reset.gnt", 32'(gnt_o[2]), 32'h0);
        end
        req = '0;
        reset_n = 1'b1;

        // Single request from requester 1.
        req = 4'b0010;
        din = 32'h0000_A500;
        step("single");
        chk("single.gnt", 32'(gnt_o[0]), 32'h2);
        chk("single.q", 32'(q_o[0]), 32'hA5);
        chk("single.owner", 32'(owner_o[0]), 32'h1);
        chk("single.qv", 32'(qv_o[0]), 32'h1);
        chk("single.busy1", 32'(busy_o[0]), 32'h1);
        req = '0;
        step("single");
        chk("single.busy2", 32'(busy_o[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("single");
            chk("single.after_q", 32'(q_o[0]), 32'hA5);
            chk("single.after_gnt", 32'(gnt_o[0]), 32'h0);
        end
        chk("single.idle_busy", 32'(busy_o[0]), 32'h0);

        // Round robin, all requesting.
        do_reset();
        req = 4'b1111;
        din = 32'h1312_1110;
        for (int i = 1; i <= 15; i++) begin
            step("rr");
            for (int b = 0; b < N; b++) begin
                if (gnt_o[0][b]) begin
                    gl.push_back(b);
                    gs.push_back(i);
                end
            end
        end
        chk("rr.count", 32'(gl.size()), 32'd5);
        for (int k = 0; k < 5 && k < gl.size(); k++) begin
            chk($sformatf("rr.who%0d", k), 32'(gl[k]), 32'(k % 4));
            chk($sformatf("rr.when%0d", k), 32'(gs[k]), 32'(1 + 3 * k));
        end
        req = '0;

        // Back-to-back writes with no lockout.
        do_reset();
        req = 4'b0011;
        din = 32'h0000_2211;
        for (int i = 0; i < 6; i++) begin
            step("b2b");
            chk("b2b.gnt", 32'(gnt_o[1]), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("b2b.busy", 32'(busy_o[1]), 32'h0);
        end
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step("b2b1");
            chk("b2b1.gnt", 32'(gnt_o[1]), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        req = '0;

        // Reset during the second lockout cycle of the HOLD=3 instance.
        do_reset();
        req = 4'b0100;
        din = 32'hAB5C_0000;
        step("midrst");
        chk("midrst.gnt", 32'(gnt_o[2]), 32'h4);
        chk("midrst.q", 32'(q_o[2]), 32'h5C);
        req = '0;
        step("midrst");
        chk("midrst.busy2", 32'(busy_o[2]), 32'h1);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("midrst.async");
        chk("midrst.async_busy", 32'(busy_o[2]), 32'h0);
        chk("midrst.async_q", 32'(q_o[2]), 32'h0);
        chk("midrst.async_qv", 32'(qv_o[2]), 32'h0);
        step("midrst.held");
        req = 4'b1000;
        reset_n = 1'b1;
        step("midrst.after");
        chk("midrst.after_gnt", 32'(gnt_o[2]), 32'h8);
        chk("midrst.after_owner", 32'(owner_o[2]), 32'h3);
        chk("midrst.after_q", 32'(q_o[2]), 32'hAB);
        req = '0;

        // Idle stability: data toggles with no requests.
        do_reset();
        req = 4'b0001;
        din = 32'h0000_003C;
        step("idle");
        req = '0;
        for (int i = 1; i <= 12; i++) begin
            din = $urandom;
            step("idle");
            chk("idle.q", 32'(q_o[0]), 32'h3C);
            if (i >= 2) chk("idle.busy", 32'(busy_o[0]), 32'h0);
            chk("idle.gnt", 32'(gnt_o[0]), 32'h0);
        end

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom_range(0, 15));
            din = $urandom;
            step("rand");
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all("rand.async");
                step("rand.held");
                reset_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
